// File: rtl/mod3_count_monitor.sv
// mod3_count_monitor: samples the ripple mod-MOD counter bus into the clk domain,
// filters settling glitches, checks each accepted value is a +1 step modulo MOD,
// pulses on wrap, counts wraps (saturating) and latches a sticky error.
module mod3_count_monitor #(
    parameter int WIDTH         = 3,
    parameter int MOD           = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clr,
    output logic [WIDTH-1:0]  cnt_out,
    output logic              cnt_valid,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              err
);

    localparam int               RUN_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 1);

    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_TRACK = 1'b1;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0]            vld_pipe;
    logic [WIDTH-1:0]                  samp, prev;
    logic                              samp_vld, prev_vld;
    logic [RUN_W-1:0]                  run, run_nxt;
    logic                              fresh, accept, take;
    logic [WIDTH-1:0]                  nxt;
    logic [0:0]                        state;

    assign samp     = sync_q[SYNC_STAGES-1];
    assign samp_vld = vld_pipe[SYNC_STAGES-1];

    // Synchronizer; vld_pipe marks which stages hold real post-reset samples so the
    // reset zeros in the chain are never mistaken for a stable input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            vld_pipe <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], cnt_in};
            vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Run length of identical samples (first sample of a run counts as 1), saturating;
    // accept exactly once, on the edge the run reaches STABLE_CYCLES.
    always_comb begin
        fresh   = !(prev_vld && (samp == prev));
        run_nxt = '0;
        if (samp_vld) begin
            if (fresh)               run_nxt = RUN_W'(1);
            else if (run == RUN_MAX) run_nxt = RUN_MAX;
            else                     run_nxt = run + 1'b1;
        end
        accept = samp_vld && (run_nxt == RUN_MAX) && (fresh || (run != RUN_MAX));
        take   = accept && ((state == S_INIT) || (samp != cnt_out));
        nxt    = (cnt_out == TOP) ? '0 : cnt_out + 1'b1;
    end

    // Filter state: previous sample and run counter (clr does not touch it).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev     <= '0;
            prev_vld <= 1'b0;
            run      <= '0;
        end else begin
            prev     <= samp;
            prev_vld <= samp_vld;
            run      <= run_nxt;
        end
    end

    // Step checker: INIT takes the first legal value as baseline, TRACK checks +1 steps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_INIT;
            cnt_out    <= '0;
            cnt_valid  <= 1'b0;
            wrap       <= 1'b0;
            wrap_count <= '0;
            err        <= 1'b0;
        end else begin
            cnt_valid <= 1'b0;
            wrap      <= 1'b0;
            if (clr) begin
                err        <= 1'b0;
                wrap_count <= '0;
                state      <= S_INIT;
            end else if (take) begin
                if (samp > TOP) begin
                    err <= 1'b1;
                end else if (state == S_INIT) begin
                    cnt_out   <= samp;
                    cnt_valid <= 1'b1;
                    state     <= S_TRACK;
                end else if (samp == nxt) begin
                    cnt_out   <= samp;
                    cnt_valid <= 1'b1;
                    if (cnt_out == TOP) begin
                        wrap <= 1'b1;
                        if (wrap_count != '1) wrap_count <= wrap_count + 1'b1;
                    end
                end else begin
                    // skipped step: flag it and resync to the observed value
                    err       <= 1'b1;
                    cnt_out   <= samp;
                    cnt_valid <= 1'b1;
                end
            end
        end
    end

endmodule
